// File: rtl/stochastic_to_binary_counter_if.sv
`default_nettype none
// ============================================================================
// Module   : stochastic_to_binary_counter_if
// Purpose  : Control/data bundle between a stochastic stream source and the
//            stochastic-to-binary counter.
// Revision : 1.0
// ============================================================================
interface stochastic_to_binary_counter_if #(
  parameter int WIDTH = 10
);
  logic             start;
  logic             en;
  logic             stochastic_number;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] binary_number;

  modport master (
    output start,
    output en,
    output stochastic_number,
    input  busy,
    input  done,
    input  binary_number
  );

  modport slave (
    input  start,
    input  en,
    input  stochastic_number,
    output busy,
    output done,
    output binary_number
  );
endinterface
`default_nettype wire

// File: rtl/stochastic_to_binary_counter.sv
`default_nettype none
// ============================================================================
// Module   : stochastic_to_binary_counter
// Purpose  : Counts high bits of a stochastic stream over 2^WIDTH enabled
//            samples and reports the (saturated) count as a binary number.
// Revision : 1.0
// ============================================================================
module stochastic_to_binary_counter #(
  parameter int WIDTH = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  stochastic_to_binary_counter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [WIDTH:0] c_LAST_SAMPLE = {1'b0, {WIDTH{1'b1}}};

  state_t           r_state;
  logic [WIDTH:0]   r_samples;
  logic [WIDTH:0]   r_ones;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_result;

  logic [WIDTH:0]   w_ones_next;
  logic             w_last;
  logic [WIDTH-1:0] w_ones_sat;

  assign w_ones_next = r_ones + {{WIDTH{1'b0}}, bus.stochastic_number};
  assign w_last      = (r_samples == c_LAST_SAMPLE);
  // An all-ones window (count 2^WIDTH) is clamped into the WIDTH-bit range.
  assign w_ones_sat  = w_ones_next[WIDTH] ? {WIDTH{1'b1}} : w_ones_next[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_samples <= '0;
      r_ones    <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_result  <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_state   <= S_COUNT;
            r_busy    <= 1'b1;
            r_samples <= '0;
            r_ones    <= '0;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_COUNT: begin
          if (bus.en) begin
            r_samples <= r_samples + 1'b1;
            r_ones    <= w_ones_next;
            if (w_last) begin
              r_result <= w_ones_sat;
              r_done   <= 1'b1;
              r_busy   <= 1'b0;
              r_state  <= S_DONE;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy          = r_busy;
  assign bus.done          = r_done;
  assign bus.binary_number = r_result;

endmodule
`default_nettype wire

// File: tb/tb_stochastic_to_binary_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_stochastic_to_binary_counter
// Purpose  : Directed and randomized windows checked against a sample-count model.
// Revision : 1.0
// ============================================================================
module tb_stochastic_to_binary_counter;
  localparam int WIDTH = 10;
  localparam int N     = 1 << WIDTH;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   last_result = 0;

  always #5 clk = ~clk;

  stochastic_to_binary_counter_if #(.WIDTH(WIDTH)) bus ();

  stochastic_to_binary_counter #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // mode: 0 const0, 1 const1, 2 alternating, 3 random bits, 4 en toggling, 5 random en+bits
  task automatic run_window(input int mode, input int prob, input int mid_start,
                            input bit chain_next, input string tag);
    int n = 0, ones = 0, en0 = 0, cyc = 0, busy_cycles = 0, bad = 0, exp, d;
    bit e, s;
    bus.start = 1'b1; bus.en = 1'b1; bus.stochastic_number = 1'b1;
    tick();
    bus.start = 1'b0;
    check({tag, "_busy_on"}, 32'(bus.busy), 1);
    while (n < N) begin
      case (mode)
        0:       begin e = 1'b1; s = 1'b0; end
        1:       begin e = 1'b1; s = 1'b1; end
        2:       begin e = 1'b1; s = (n % 2 == 0); end
        3:       begin e = 1'b1; s = ($urandom_range(N - 1, 0) < prob); end
        4:       begin e = (cyc % 2 == 1); s = !e; end
        default: begin e = ($urandom_range(3, 0) != 0); s = ($urandom_range(N - 1, 0) < prob); end
      endcase
      bus.en = e;
      bus.stochastic_number = s;
      bus.start = (cyc == mid_start);
      if (bus.busy === 1'b1) busy_cycles++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b1 || bus.binary_number !== WIDTH'(last_result)) bad++;
      tick();
      cyc++;
      if (e) begin n++; ones += int'(s); end
      else en0++;
    end
    bus.en = 1'b0; bus.stochastic_number = 1'b0; bus.start = chain_next;
    exp = (ones >= N) ? N - 1 : ones;
    check({tag, "_done"},        32'(bus.done), 1);
    check({tag, "_busy_off"},    32'(bus.busy), 0);
    check({tag, "_result"},      32'(bus.binary_number), exp);
    check({tag, "_busy_cycles"}, busy_cycles, N + en0);
    check({tag, "_window_bad"},  bad, 0);
    if (mode == 3) begin
      d = int'(bus.binary_number) - prob;
      if (d < 0) d = -d;
      check({tag, "_within_64"}, 32'(d <= 64), 1);
    end
    last_result = exp;
    if (!chain_next) begin
      tick();
      check({tag, "_done_one_cycle"}, 32'(bus.done), 0);
      check({tag, "_held"}, 32'(bus.binary_number), exp);
    end
  endtask

  initial begin
    int seen_done;
    rst = 1'b1; bus.start = 1'b0; bus.en = 1'b0; bus.stochastic_number = 1'b0;
    repeat (3) tick();
    check("reset_busy",   32'(bus.busy), 0);
    check("reset_done",   32'(bus.done), 0);
    check("reset_result", 32'(bus.binary_number), 0);
    rst = 1'b0;
    tick();
    check("idle_busy", 32'(bus.busy), 0);

    run_window(0, 0, -1, 1'b0, "const0");
    run_window(1, 0, -1, 1'b0, "const1");
    run_window(2, 0, -1, 1'b1, "alt_a");
    run_window(2, 0, -1, 1'b0, "alt_b_back2back");
    run_window(3, 511, -1, 1'b0, "rand511");
    run_window(3, 255, -1, 1'b0, "rand255");
    run_window(3, 341, -1, 1'b0, "rand341");
    run_window(4, 0, -1, 1'b0, "en_toggle");
    run_window(5, int'($urandom_range(N - 1, 0)), -1, 1'b0, "rand_en");
    run_window(2, 0, -1, 1'b0, "alt_pre_rst");

    // Abort a window part-way with reset; start held high to confirm reset priority.
    bus.start = 1'b1; bus.en = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 300; i++) begin
      bus.stochastic_number = (i % 2 == 0);
      tick();
    end
    rst = 1'b1; bus.start = 1'b1;
    seen_done = 0;
    repeat (3) begin
      tick();
      if (bus.done !== 1'b0) seen_done++;
    end
    check("rst_mid_busy",   32'(bus.busy), 0);
    check("rst_mid_result", 32'(bus.binary_number), 0);
    rst = 1'b0; bus.start = 1'b0; bus.en = 1'b0;
    tick();
    if (bus.done !== 1'b0) seen_done++;
    check("rst_no_done",    seen_done, 0);
    check("rst_after_busy", 32'(bus.busy), 0);
    last_result = 0;

    run_window(1, 0, 200, 1'b0, "post_rst_const1_midstart");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
